// File: rtl/axis_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_fifo_ctrl_if
// Brief    : AXI4-Stream handshake bundle (tvalid/tready/tdata/tlast).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_fifo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_fifo_ctrl
// Brief    : AXIS FIFO control: pointers, occupancy, flags and a registered
//            first-word-fall-through output stage. Optional macro
//            PACKET_MODE_EN enables store-and-forward release.
// Revision : 1.0 - initial release
// ============================================================================
module axis_fifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  axis_fifo_ctrl_if.slave  s_axis,
  axis_fifo_ctrl_if.master m_axis,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH:0]   mem_wdata,
  output logic             mem_re,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH:0]   mem_rdata,
  output logic [AW+1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW+1:0] CNT_ONE = {{(AW+1){1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic             m_tlast_q, m_tlast_d;
  logic [AW+1:0]    count_q, count_d;

  logic mem_full, mem_empty;
  logic push, load, pop;
  logic load_gate;

  // Wrap bit differs with equal index bits: the memory is full, not empty.
  assign mem_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign mem_empty = (wptr_q == rptr_q);
  assign push      = s_axis.tvalid && !mem_full;
  assign pop       = m_tvalid_q && m_axis.tready;
  assign load      = !mem_empty && (!m_tvalid_q || m_axis.tready) && load_gate;

`ifdef PACKET_MODE_EN
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;

  // A full memory releases words even without a complete packet, so packets
  // longer than DEPTH stream cut-through instead of deadlocking.
  assign load_gate = (pkt_cnt_q != '0) || mem_full;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push && s_axis.tlast) pkt_cnt_d = pkt_cnt_d + PTR_ONE;
    if (load && mem_rdata[WIDTH]) pkt_cnt_d = pkt_cnt_d - PTR_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end
`else
  assign load_gate = 1'b1;
`endif

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    count_d    = count_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (load) begin
      rptr_d     = rptr_q + PTR_ONE;
      m_tvalid_d = 1'b1;
      m_tdata_d  = mem_rdata[WIDTH-1:0];
      m_tlast_d  = mem_rdata[WIDTH];
    end else if (pop) begin
      m_tvalid_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      count_q    <= count_d;
    end
  end

  assign s_axis.tready = !mem_full;
  assign mem_we        = push;
  assign mem_waddr     = wptr_q[AW-1:0];
  assign mem_wdata     = {s_axis.tlast, s_axis.tdata};
  assign mem_re        = load;
  assign mem_raddr     = rptr_q[AW-1:0];
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tlast  = m_tlast_q;
  assign count         = count_q;
  assign full          = mem_full;
  assign empty         = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_fifo_ctrl
// Brief    : Directed bench for axis_fifo_ctrl with a queue-level reference
//            model checked every cycle. Honours PACKET_MODE_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  axis_fifo_ctrl_if #(.WIDTH(WIDTH)) s_if ();
  axis_fifo_ctrl_if #(.WIDTH(WIDTH)) m_if ();

  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [WIDTH:0]   mem_wdata, mem_rdata;
  logic [AW+1:0]    count;
  logic             full, empty;

  axis_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Dual-port memory with combinational read
  logic [WIDTH:0] mem [DEPTH];
  always @(posedge clock) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  int vectors     = 0;
  int miscompares = 0;
  int dut_pops    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) if (reset_n && m_if.tvalid && m_if.tready) dut_pops++;

  // Reference model: memory as a queue plus a one-word output slot
  logic [WIDTH:0] mq[$];
  bit             ov = 1'b0;
  logic [WIDTH:0] od = '0;
  int             wr_n = 0, rd_n = 0, pk = 0;
  bit             mp, ml, mpp;
  logic [WIDTH:0] mw;

  function automatic bit mdl_push();
    return s_if.tvalid && (mq.size() < DEPTH);
  endfunction

  function automatic bit mdl_load();
    bit g;
    g = 1'b1;
`ifdef PACKET_MODE_EN
    g = (pk != 0) || (mq.size() == DEPTH);
`endif
    return (mq.size() != 0) && (!ov || m_if.tready) && g;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      ov = 1'b0; od = '0; wr_n = 0; rd_n = 0; pk = 0;
    end else begin
      mp  = mdl_push();
      ml  = mdl_load();
      mpp = ov && m_if.tready;
      if (ml) begin
        mw = mq.pop_front();
        od = mw; ov = 1'b1; rd_n++;
        if (mw[WIDTH]) pk--;
      end else if (mpp) begin
        ov = 1'b0;
      end
      if (mp) begin
        mq.push_back({s_if.tlast, s_if.tdata});
        wr_n++;
        if (s_if.tlast) pk++;
      end
    end
  end

  always @(negedge clock) begin
    int sz;
    sz = mq.size();
    chk("s_tready", s_if.tready, sz < DEPTH);
    chk("m_tvalid", m_if.tvalid, ov);
    chk("m_tdata", m_if.tdata, od[WIDTH-1:0]);
    chk("m_tlast", m_if.tlast, od[WIDTH]);
    chk("count", count, sz + int'(ov));
    chk("full", full, sz == DEPTH);
    chk("empty", empty, (sz + int'(ov)) == 0);
    chk("mem_we", mem_we, mdl_push());
    if (mdl_push()) begin
      chk("mem_waddr", mem_waddr, wr_n % DEPTH);
      chk("mem_wdata", mem_wdata, {s_if.tlast, s_if.tdata});
    end
    chk("mem_re", mem_re, mdl_load());
    if (mdl_load()) chk("mem_raddr", mem_raddr, rd_n % DEPTH);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted
  task automatic push_word(input logic [WIDTH-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      done = s_if.tready;
      tick();
    end
    if (!done) chk("push_timeout", 0, 1);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  initial begin
    int p0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_s_tready", s_if.tready, 1);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);

    // Single word, latency and count 1->0
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 32'hA5A5_0001; s_if.tlast = 1'b1;
    tick();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    chk("t1_count_after_push", count, 1);
    chk("t1_mvalid_after_push", m_if.tvalid, 0);
    tick();
    chk("t1_mvalid", m_if.tvalid, 1);
    chk("t1_mdata", m_if.tdata, 32'hA5A5_0001);
    chk("t1_mlast", m_if.tlast, 1);
    chk("t1_count_loaded", count, 1);
    tick();
    chk("t1_count_drained", count, 0);
    chk("t1_mvalid_drained", m_if.tvalid, 0);

    // Fill to DEPTH+1 with downstream stalled
    m_if.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h1000 + i; s_if.tlast = (i == 16);
      chk("t2_s_tready_fill", s_if.tready, 1);
      tick();
    end
    chk("t2_s_tready_full", s_if.tready, 0);
    chk("t2_full", full, 1);
    chk("t2_count", count, 17);
    s_if.tdata = 32'hDEAD_BEEF; s_if.tlast = 1'b0;
    #1;
    chk("t2_no_we", mem_we, 0);
    tick();
    chk("t2_count_held", count, 17);
    chk("t2_head", m_if.tdata, 32'h1000);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (20) tick();
    chk("t2_drained_count", count, 0);
    chk("t2_drained_empty", empty, 1);

    // Streaming, both sides always ready (steady-state: 1 in mem + 1 in output reg)
    p0 = dut_pops;
    for (int k = 1; k <= 100; k++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h2000 + k - 1;
      tick();
      chk("t3_count", count, (k == 1) ? 1 : 2);
      if (k >= 2) begin
        chk("t3_mvalid", m_if.tvalid, 1);
        chk("t3_mdata", m_if.tdata, 32'h2000 + k - 2);
      end
    end
    s_if.tvalid = 1'b0;
    repeat (3) tick();
    chk("t3_pops", dut_pops - p0, 100);
    chk("t3_count_end", count, 0);

    // Stall while valid, then release
    m_if.tready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h3000 + j; s_if.tlast = (j == 3);
      tick();
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (5) begin
      chk("t4_stall_valid", m_if.tvalid, 1);
      chk("t4_stall_data", m_if.tdata, 32'h3000);
      chk("t4_stall_last", m_if.tlast, 0);
      tick();
    end
    m_if.tready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("t4_rel_valid", m_if.tvalid, 1);
      chk("t4_rel_data", m_if.tdata, 32'h3000 + j);
      chk("t4_rel_last", m_if.tlast, j == 3);
    end
    tick();
    chk("t4_done_valid", m_if.tvalid, 0);
    chk("t4_done_hold", m_if.tdata, 32'h3003);

    // Asynchronous reset mid-stream with 8 words held
    m_if.tready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h4000 + j;
      tick();
    end
    s_if.tvalid = 1'b0;
    chk("t5_count_pre", count, 8);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_mvalid", m_if.tvalid, 0);
    chk("t5_rst_mdata", m_if.tdata, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_sready", s_if.tready, 1);
    tick();
    reset_n = 1'b1;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 32'h5000; s_if.tlast = 1'b1;
    #1;
    chk("t5_we", mem_we, 1);
    chk("t5_waddr", mem_waddr, 0);
    tick();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    tick();
    chk("t5_mvalid", m_if.tvalid, 1);
    chk("t5_mdata", m_if.tdata, 32'h5000);
    tick();
    chk("t5_count_end", count, 0);

`ifdef PACKET_MODE_EN
    // Store-and-forward: nothing leaves before the tlast word arrives
    m_if.tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h6000 + j; s_if.tlast = (j == 3);
      tick();
      chk("t6_hold_mvalid", m_if.tvalid, 0);
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    tick();
    chk("t6_release_mvalid", m_if.tvalid, 1);
    chk("t6_release_mdata", m_if.tdata, 32'h6000);
    repeat (6) tick();
    chk("t6_count_end", count, 0);

    // Oversize packet escapes through the full-memory path
    p0 = dut_pops;
    for (int j = 0; j < 20; j++) push_word(32'h7000 + j, j == 19);
    repeat (10) tick();
    chk("t6_long_pops", dut_pops - p0, 20);
    chk("t6_long_count", count, 0);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
